// File: rtl/sps_burst_ctrl.sv
// sps_burst_ctrl: start-triggered pulse-train sequencer (pre-delay, N pulses of width W, gaps G)
// with abort, done and completed-pulse count; all outputs registered.
module sps_burst_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [CNT_W-1:0] pulse_width,
    input  logic [CNT_W-1:0] gap_width,
    input  logic [CNT_W-1:0] pre_delay,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] pulse_cnt
);
    typedef enum logic [1:0] {IDLE, PRE, HIGH, LOW} state_t;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    state_t st, nst;
    logic [CNT_W-1:0] cnt, cnt_n, n_q, w_q, g_q, n_n, w_n, g_n, pcnt_n;
    logic accept, phase_end, last, pulse_n, busy_n, done_n, aborted_n;
    assign accept    = st == IDLE && start && !abort;
    assign phase_end = cnt == ONE;
    // widened compare so pulse_cnt+1 cannot wrap at the maximum burst length
    assign last      = {1'b0, pulse_cnt} + (CNT_W+1)'(1) >= {1'b0, n_q};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            cnt       <= '0;
            n_q       <= '0;
            w_q       <= '0;
            g_q       <= '0;
            pulse_cnt <= '0;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            st        <= nst;
            cnt       <= cnt_n;
            n_q       <= n_n;
            w_q       <= w_n;
            g_q       <= g_n;
            pulse_cnt <= pcnt_n;
            pulse_out <= pulse_n;
            busy      <= busy_n;
            done      <= done_n;
            aborted   <= aborted_n;
        end
    end
    always_comb begin
        nst = st;
        if (st != IDLE && abort) nst = IDLE;
        else if (accept) nst = burst_len == '0 ? IDLE : pre_delay == '0 ? HIGH : PRE;
        else if (phase_end) nst = st == HIGH ? (last ? IDLE : LOW) : HIGH;
    end
    // cnt holds the cycles remaining in the current phase, loaded on each phase entry
    always_comb begin
        n_n       = accept ? burst_len : n_q;
        w_n       = accept ? (pulse_width == '0 ? ONE : pulse_width) : w_q;
        g_n       = accept ? (gap_width == '0 ? ONE : gap_width) : g_q;
        cnt_n     = nst == IDLE ? '0 : nst != st ? (nst == PRE ? pre_delay : nst == HIGH ? w_n : g_q) : cnt - ONE;
        pcnt_n    = accept ? '0 : (st == HIGH && !abort && phase_end) ? pulse_cnt + ONE : pulse_cnt;
        pulse_n   = nst == HIGH;
        busy_n    = nst != IDLE;
        done_n    = (accept && burst_len == '0) || (st == HIGH && !abort && phase_end && last);
        aborted_n = st != IDLE && abort;
    end
endmodule

// File: tb/tb_sps_burst_ctrl.sv
// tb_sps_burst_ctrl: directed bench with a timeline-based burst model checked every cycle
// plus literal expectations for the documented scenarios.
module tb_sps_burst_ctrl;
    localparam int CW = 16;
    logic clk = 0, rst = 1, start = 0, abort = 0;
    logic [CW-1:0] burst_len = '0, pulse_width = '0, gap_width = '0, pre_delay = '0;
    logic pulse_out, busy, done, aborted;
    logic [CW-1:0] pulse_cnt;
    int checks = 0, errors = 0;
    bit m_act;
    int m_r, m_n, m_w, m_g, m_d, m_len;
    bit e_pulse, e_busy, e_done, e_ab;
    int e_cnt;
    logic [15:0] cp, cb, cd;

    always #5 clk = ~clk;

    sps_burst_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .burst_len(burst_len), .pulse_width(pulse_width), .gap_width(gap_width), .pre_delay(pre_delay),
        .pulse_out(pulse_out), .busy(busy), .done(done), .aborted(aborted), .pulse_cnt(pulse_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // position r within the burst timeline -> expected pulse level and completed pulses
    task automatic phase();
        int t, k, ph;
        e_busy = 1;
        t = m_r - m_d;
        if (t <= 0) begin
            e_pulse = 0;
            e_cnt = 0;
        end else begin
            k = (t - 1) / (m_w + m_g);
            ph = (t - 1) % (m_w + m_g);
            e_pulse = ph < m_w;
            e_cnt = ph < m_w ? k : k + 1;
        end
    endtask

    task automatic model_step();
        e_done = 0;
        e_ab = 0;
        if (rst) begin
            m_act = 0; e_pulse = 0; e_busy = 0; e_cnt = 0;
        end else if (m_act) begin
            if (abort) begin
                m_act = 0; e_ab = 1; e_pulse = 0; e_busy = 0;
            end else begin
                m_r++;
                if (m_r > m_len) begin
                    m_act = 0; e_done = 1; e_cnt = m_n; e_pulse = 0; e_busy = 0;
                end else phase();
            end
        end else if (start && !abort) begin
            m_n = int'(burst_len);
            m_w = pulse_width == 0 ? 1 : int'(pulse_width);
            m_g = gap_width == 0 ? 1 : int'(gap_width);
            m_d = int'(pre_delay);
            e_cnt = 0;
            if (m_n == 0) e_done = 1;
            else begin
                m_act = 1;
                m_r = 1;
                m_len = m_d + m_n * m_w + (m_n - 1) * m_g;
                phase();
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("pulse_out", pulse_out, e_pulse);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("aborted", aborted, e_ab);
        chk("pulse_cnt", pulse_cnt, e_cnt);
    endtask

    task automatic cfg(input int n, input int w, input int g, input int d);
        burst_len = CW'(n); pulse_width = CW'(w); gap_width = CW'(g); pre_delay = CW'(d);
    endtask

    task automatic run(input int n);
        cp = '0; cb = '0; cd = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == 0) start = 0;
            cp[i] = pulse_out; cb[i] = busy; cd[i] = done;
        end
    endtask

    initial begin
        tick();
        tick();
        #1 rst = 0;
        for (int i = 0; i < 20; i++) tick();
        chk("idle_outputs", {pulse_out, busy, done, aborted}, 4'b0000);
        chk("idle_cnt", pulse_cnt, 0);

        cfg(3, 2, 1, 0); start = 1;
        run(10);
        chk("t1_pulse", cp, 16'h00DB);
        chk("t1_busy", cb, 16'h00FF);
        chk("t1_done", cd, 16'h0100);
        chk("t1_cnt", pulse_cnt, 3);

        cfg(2, 1, 0, 4); start = 1;
        run(9);
        chk("t2_pulse", cp, 16'h0050);
        chk("t2_busy", cb, 16'h007F);
        chk("t2_done", cd, 16'h0080);

        cfg(0, 3, 3, 3); start = 1;
        run(3);
        chk("t3_done", cd, 16'h0001);
        chk("t3_busy_pulse", {cb, cp}, 32'h0);
        chk("t3_cnt", pulse_cnt, 0);

        cfg(5, 3, 2, 0); start = 1;
        cp = '0;
        for (int i = 0; i < 9; i++) begin
            tick();
            cp[i] = pulse_out;
            if (i == 0) start = 0;
            if (i == 2) begin cfg(1, 7, 7, 0); start = 1; end
            if (i == 3) start = 0;
            if (i == 5) abort = 1;
            if (i == 6) begin
                chk("t4_abort_state", {pulse_out, busy, aborted, done}, 4'b0010);
                chk("t4_abort_cnt", pulse_cnt, 1);
                abort = 0;
            end
            if (i == 7) chk("t4_aborted_pulse", aborted, 0);
        end
        chk("t4_pulse", cp[6:0], 7'h27);

        start = 1; abort = 1; cfg(2, 2, 2, 0);
        tick();
        start = 0;
        chk("start_abort_idle", {busy, aborted, done, pulse_out}, 4'b0000);
        tick();
        abort = 0;
        chk("abort_idle", aborted, 0);

        cfg(2, 4, 1, 0); start = 1;
        tick();
        start = 0;
        tick();
        #2 rst = 1;
        #1;
        chk("async_rst_out", {pulse_out, busy, done, aborted}, 4'b0000);
        chk("async_rst_cnt", pulse_cnt, 0);
        tick();
        rst = 0;
        tick();

        cfg(1, 2, 0, 0); start = 1;
        cp = '0; cb = '0; cd = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            cp[i] = pulse_out; cb[i] = busy; cd[i] = done;
            if (i == 0) start = 0;
            if (i == 2) begin cfg(2, 1, 1, 0); start = 1; end
            if (i == 3) start = 0;
        end
        chk("t6_pulse", cp[7:0], 8'h2B);
        chk("t6_busy", cb[7:0], 8'h3B);
        chk("t6_done", cd[7:0], 8'h44);
        chk("t6_cnt", pulse_cnt, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
